// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
// The 2-bit Tuse/Tnew type is also used by the decoder and pipeline registers.
package hazard_stall_ctrl_pkg;

  typedef logic [1:0] tstage_t;

  localparam tstage_t TUSE_NONE       = 2'd3;
  localparam int      MD_DIV_BIT      = 1;
  localparam int      MULT_CYCLES_DEF = 5;
  localparam int      DIV_CYCLES_DEF  = 10;
  localparam int      MD_CNT_W        = 4;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy.sv
// Mult/div busy counter: loads the unit latency on a start pulse and counts down.
// md_busy is derived straight from the count register, so it is glitch-free.
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  logic [MD_CNT_W-1:0] cnt;

  // A start while already counting cannot happen legally; it is ignored.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (md_start && cnt == '0)
      cnt <= md_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detection (Tuse/Tnew against EX and MEM) plus HI/LO interlock;
// drives PC / IF_ID hold, ID_EX bubble and ID_EX flush, and counts stall cycles.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  tstage_t     id_tuse_rs,
  input  tstage_t     id_tuse_rt,
  input  logic        id_md,
  input  logic [4:0]  ex_wa,
  input  logic        ex_regwrite,
  input  tstage_t     ex_tnew,
  input  logic [4:0]  mem_wa,
  input  logic        mem_regwrite,
  input  tstage_t     mem_tnew,
  input  logic        md_start,
  input  logic [1:0]  md_op,
  input  logic        int_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic stall_ex, stall_mem, stall_md, stall;
  logic md_op_unused;

  // Equal Tuse/Tnew is covered by forwarding; Tuse = 3 (unused) never exceeds Tnew.
  function automatic logic src_hazard(input logic [4:0] wa, input logic we,
                                      input tstage_t tnew);
    return we && (wa != 5'd0) &&
           ((wa == id_rs && id_tuse_rs < tnew) || (wa == id_rt && id_tuse_rt < tnew));
  endfunction

  assign stall_ex  = src_hazard(ex_wa, ex_regwrite, ex_tnew);
  assign stall_mem = src_hazard(mem_wa, mem_regwrite, mem_tnew);
  assign stall_md  = id_md && (md_busy || md_start);
  assign stall     = stall_ex || stall_mem || stall_md;

  // The interrupt wins: PC loads the handler even while a stall is pending.
  assign pc_en       = !stall || int_req;
  assign if_id_en    = !stall || int_req;
  assign id_ex_en    = !stall;
  assign id_ex_flush = int_req;

  assign md_op_unused = md_op[0];

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_div   (md_op[MD_DIV_BIT]),
    .md_busy  (md_busy)
  );

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && !int_req)
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Generates the stall and flush controls consumed by the IF/ID and ID/EX pipeline registers and by the PC.
- Drives PC/IF_ID hold, the ID_EX en (0 = insert bubble) and the ID_EX flush line (IntBeq).
- Hazard detection uses Tuse/Tnew comparison against the EX and MEM stages.
- Owns the multiply/divide busy counter that interlocks HI/LO instructions in ID.

Parameters:
- MULT_CYCLES, 5, cycles the mult/multu unit stays busy after its start pulse.
- DIV_CYCLES, 10, cycles the div/divu unit stays busy after its start pulse.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_tuse_rs  in  2  cycles until ID instruction needs rs (3 = not used)
- id_tuse_rt  in  2  cycles until ID instruction needs rt (3 = not used)
- id_md  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- ex_wa  in  5  destination register in EX
- ex_regwrite  in  1  EX instruction writes GPR
- ex_tnew  in  2  cycles until EX result is available
- mem_wa  in  5  destination register in MEM
- mem_regwrite  in  1  MEM instruction writes GPR
- mem_tnew  in  2  cycles until MEM result is available
- md_start  in  1  MultDivStart from the ID_EX output (EX stage)
- md_op  in  2  MultDivOp from EX; bit1 = 1 is divide
- int_req  in  1  exception/interrupt taken this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID enable
- id_ex_en  out  1  ID_EX en (0 = bubble)
- id_ex_flush  out  1  ID_EX flush (IntBeq)
- md_busy  out  1  mult/div unit busy
- stall_cnt  out  32  total stall cycles since reset

Behaviour:
- stall_ex = ex_regwrite & (ex_wa != 0) & ((ex_wa == id_rs & id_tuse_rs < ex_tnew) | (ex_wa == id_rt & id_tuse_rt < ex_tnew)).
- stall_mem: same expression using the mem_* inputs.
- stall_md = id_md & (md_busy | md_start).
- stall = stall_ex | stall_mem | stall_md.
- Combinational outputs:
  - pc_en = if_id_en = ~stall | int_req.
  - id_ex_en = ~stall.
  - id_ex_flush = int_req.
  - int_req dominates: the PC loads the handler even when a stall condition is present.
- Busy counter (cnt, 4 bits, registered):
  - On clk with rst: cnt <= 0.
  - Else if md_start and cnt == 0: cnt <= md_op[1] ? DIV_CYCLES : MULT_CYCLES.
  - Else if cnt != 0: cnt <= cnt - 1.
  - md_start while cnt != 0 is illegal (prevented by stall_md) and is ignored; the count continues.
- md_busy = (cnt != 0), registered.
  - The start pulse is seen in cycle T; busy is high for cycles T+1 .. T+N.
  - An HI/LO instruction in ID is held from T through T+N and issues in T+N+1.
- int_req does not abort an in-flight mult/div; the counter keeps running.
- stall_cnt: rst clears it to 0. Otherwise it increments when stall & ~int_req, and wraps at 2^32-1 to 0.
- Reset values: cnt = 0, md_busy = 0, stall_cnt = 0. With all inputs at 0 during and after reset: pc_en = 1, if_id_en = 1, id_ex_en = 1, id_ex_flush = 0.
- Reset mid-operation: a busy count is cleared in the same edge, and md_busy is 0 the next cycle.
- Register $0 never causes a stall.
- Equal Tuse and Tnew never stalls, because forwarding covers that case.

Decomposition:
- Shared package holds:
  - TUSE_NONE = 2'd3
  - MD_DIV_BIT = 1
  - Default MULT_CYCLES and DIV_CYCLES
  - The 2-bit Tuse/Tnew type used by the decoder and pipeline registers
- One sub-module, md_busy_counter, contains the cnt register, its load and decrement, and md_busy.
- Hazard comparison stays in the top level.

Test Plan:
1. Load-use:
   - Stimulus: ex_regwrite = 1, ex_wa = 8, ex_tnew = 2, id_rs = 8, id_tuse_rs = 1.
   - Response: pc_en = 0, if_id_en = 0, id_ex_en = 0, flush = 0; stall_cnt increments by 1.
   - Repeat with ex_wa = 0: no stall.
2. MEM hazard:
   - Stimulus: mem_regwrite = 1, mem_wa = 5, mem_tnew = 1, id_rt = 5, id_tuse_rt = 0.
   - Response: stall.
   - Repeat with id_tuse_rt = 1: no stall.
3. Divide interlock:
   - Stimulus: md_start = 1, md_op = 2'b10 at cycle T; id_md = 1 held.
   - Response: md_busy high for T+1..T+10; id_ex_en = 0 for T..T+10; id_ex_en = 1 at T+11.
4. Multiply interlock:
   - Stimulus: md_op = 2'b00 at T.
   - Response: md_busy high for exactly 5 cycles; an instruction with id_md = 0 in ID is never stalled.
5. Interrupt during stall:
   - Stimulus: load-use condition plus int_req = 1.
   - Response: pc_en = 1, id_ex_flush = 1, id_ex_en = 0; stall_cnt unchanged.
6. Reset mid-divide:
   - Stimulus: rst = 1 at T+3 after a div start.
   - Response: md_busy = 0 from T+4; stall_cnt = 0; all enables = 1 with idle inputs.
